// File: rtl/wb_retire_buffer.sv
`default_nettype none
// ============================================================================
// Module   : wb_retire_buffer
// Purpose  : Write-back stage. Extends MEM-stage load data, selects the
//            write-back value, queues {a3, wd} in a DEPTH-entry FIFO and
//            drains it into a shared, per-cycle granted register-file port.
//            Queued results can be bypassed through a forwarding query.
// Ports    : clk, reset (sync, active-low)
//            [flush]                   - only when WB_FLUSH_EN is defined
//            in_valid/in_ready         - MEM-stage handshake
//            in_a3, in_wd_sel          - destination / source select
//            in_alu, in_dm, in_pc8, in_aux, in_off, in_lw_sel - data inputs
//            rf_grant, rf_we, rf_a3, rf_wd - register-file write request
//            q_addr, q_hit, q_data     - forwarding query
//            count                     - occupancy
//            dm_rd_ext                 - extended load value of current input
// Optional : WB_FLUSH_EN adds the flush input.
// Revision : 1.0 - initial release
// ============================================================================
module wb_retire_buffer #(
   parameter int DW    = 32,
   parameter int AW    = 5,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
`ifdef WB_FLUSH_EN
   input  logic                       flush,
`endif
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [AW-1:0]              in_a3,
   input  logic [1:0]                 in_wd_sel,
   input  logic [DW-1:0]              in_alu,
   input  logic [DW-1:0]              in_dm,
   input  logic [DW-1:0]              in_pc8,
   input  logic [DW-1:0]              in_aux,
   input  logic [1:0]                 in_off,
   input  logic [2:0]                 in_lw_sel,
   input  logic                       rf_grant,
   output logic                       rf_we,
   output logic [AW-1:0]              rf_a3,
   output logic [DW-1:0]              rf_wd,
   input  logic [AW-1:0]              q_addr,
   output logic                       q_hit,
   output logic [DW-1:0]              q_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic [DW-1:0]              dm_rd_ext
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [2:0] LW_LBU = 3'b001;
   localparam logic [2:0] LW_LB  = 3'b010;
   localparam logic [2:0] LW_LHU = 3'b011;
   localparam logic [2:0] LW_LH  = 3'b100;

   logic [AW-1:0] mem_a3 [DEPTH];
   logic [DW-1:0] mem_wd [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] cnt;

   logic          flush_act;
   logic          full;
   logic          push_ok;
   logic          enq;
   logic          pop;
   logic [CW-1:0] cnt_next;
   logic [CW-1:0] remaining;
   logic [PW-1:0] head_next;
   logic [AW-1:0] nxt_a3;
   logic [DW-1:0] nxt_wd;
   logic [DW-1:0] wd_sel_val;
   logic [7:0]    byte_val;
   logic [15:0]   half_val;

`ifdef WB_FLUSH_EN
   assign flush_act = flush;
`else
   assign flush_act = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // Load extension and write-back source select
   // ---------------------------------------------------------------------
   assign byte_val = in_dm[{in_off, 3'b000} +: 8];
   // Halfword offset uses only off[1]; a misaligned off[0] is ignored.
   assign half_val = in_dm[{in_off[1], 4'b0000} +: 16];

   always_comb begin
      dm_rd_ext = DW'(in_dm[31:0]);
      case (in_lw_sel)
         LW_LBU:  dm_rd_ext = DW'(byte_val);
         LW_LB:   dm_rd_ext = DW'($signed(byte_val));
         LW_LHU:  dm_rd_ext = DW'(half_val);
         LW_LH:   dm_rd_ext = DW'($signed(half_val));
         default: dm_rd_ext = DW'(in_dm[31:0]);
      endcase
   end

   always_comb begin
      wd_sel_val = in_alu;
      case (in_wd_sel)
         2'b00:   wd_sel_val = in_alu;
         2'b01:   wd_sel_val = dm_rd_ext;
         2'b10:   wd_sel_val = in_pc8;
         default: wd_sel_val = in_aux;
      endcase
   end

   // ---------------------------------------------------------------------
   // Handshake and occupancy
   // ---------------------------------------------------------------------
   assign full     = (cnt == CW'(DEPTH));
   // No pass-through when full: a same-cycle pop does not open a slot.
   assign in_ready = !full && !flush_act;
   assign push_ok  = in_valid && in_ready;
   // Writes to $0 complete the handshake but are never queued.
   assign enq      = push_ok && (in_a3 != '0);
   assign pop      = rf_we && rf_grant;
   assign cnt_next = cnt + CW'(enq) - CW'(pop);
   assign count    = cnt;

   // Next head entry, used to load the registered rf_* outputs. When the
   // queue would be empty apart from this cycle's push, the head is the
   // incoming entry, which is not yet in storage.
   assign remaining = cnt - CW'(pop);
   assign head_next = pop ? head + PW'(1) : head;

   always_comb begin
      if (remaining == '0) begin
         nxt_a3 = in_a3;
         nxt_wd = wd_sel_val;
      end else begin
         nxt_a3 = mem_a3[head_next];
         nxt_wd = mem_wd[head_next];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         cnt   <= '0;
         rf_we <= 1'b0;
         rf_a3 <= '0;
         rf_wd <= '0;
      end else if (flush_act) begin
         head  <= '0;
         tail  <= '0;
         cnt   <= '0;
         rf_we <= 1'b0;
      end else begin
         if (enq) begin
            tail <= tail + PW'(1);
         end
         head <= head_next;
         cnt  <= cnt_next;
         // rf_a3/rf_wd only update while something remains queued, so they
         // hold the last retired entry when the buffer runs empty.
         if (cnt_next != '0) begin
            rf_we <= 1'b1;
            rf_a3 <= nxt_a3;
            rf_wd <= nxt_wd;
         end else begin
            rf_we <= 1'b0;
         end
      end
   end

   // Storage needs no reset: validity is carried by head/cnt.
   always_ff @(posedge clk) begin
      if (reset && !flush_act && enq) begin
         mem_a3[tail] <= in_a3;
         mem_wd[tail] <= wd_sel_val;
      end
   end

   // ---------------------------------------------------------------------
   // Forwarding: scan oldest to youngest so the youngest match wins. The
   // popping entry is still inside cnt, and a pushing entry is not yet.
   // ---------------------------------------------------------------------
   always_comb begin
      logic [PW-1:0] idx;
      q_hit  = 1'b0;
      q_data = '0;
      idx    = '0;
      if (q_addr != '0) begin
         for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < cnt) && (mem_a3[idx] == q_addr)) begin
               q_hit  = 1'b1;
               q_data = mem_wd[idx];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_wb_retire_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_retire_buffer
// Purpose  : Self-checking bench for wb_retire_buffer. A load-extension
//            vector table, hand-written multi-cycle sequences, and a queue
//            scoreboard that tracks every accepted entry until retirement.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_retire_buffer;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] in_a3;
   logic [1:0]    in_wd_sel;
   logic [DW-1:0] in_alu, in_dm, in_pc8, in_aux;
   logic [1:0]    in_off;
   logic [2:0]    in_lw_sel;
   logic          rf_grant;
   logic          rf_we;
   logic [AW-1:0] rf_a3;
   logic [DW-1:0] rf_wd;
   logic [AW-1:0] q_addr;
   logic          q_hit;
   logic [DW-1:0] q_data;
   logic [$clog2(DEPTH):0] count;
   logic [DW-1:0] dm_rd_ext;

   always #5 clk = ~clk;

   wb_retire_buffer #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
`ifdef WB_FLUSH_EN
      .flush     (flush),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a3     (in_a3),
      .in_wd_sel (in_wd_sel),
      .in_alu    (in_alu),
      .in_dm     (in_dm),
      .in_pc8    (in_pc8),
      .in_aux    (in_aux),
      .in_off    (in_off),
      .in_lw_sel (in_lw_sel),
      .rf_grant  (rf_grant),
      .rf_we     (rf_we),
      .rf_a3     (rf_a3),
      .rf_wd     (rf_wd),
      .q_addr    (q_addr),
      .q_hit     (q_hit),
      .q_data    (q_data),
      .count     (count),
      .dm_rd_ext (dm_rd_ext)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [AW-1:0] a3;
      logic [DW-1:0] wd;
   } ent_t;

   ent_t          sb[$];
   logic [DW-1:0] exp_wd;       // expected write-back value of current input
   bit            mon_en = 1'b0;

   typedef struct {
      logic [31:0] dm;
      logic [1:0]  off;
      logic [2:0]  lw;
      logic [31:0] exp;
   } ext_vec_t;

   ext_vec_t vecs[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: compares outputs mid-cycle, then updates the model
   // with what the next rising edge will do given the stable inputs.
   int            mon_n;
   logic          mon_hit;
   logic [DW-1:0] mon_data;

   always @(negedge clk) begin
      if (mon_en) begin
         mon_n = sb.size();
         chk("mon_count", count, mon_n);
         chk("mon_in_ready", in_ready, (mon_n < DEPTH) && !flush);
         chk("mon_rf_we", rf_we, mon_n != 0);
         if (mon_n != 0) begin
            chk("mon_rf_a3", rf_a3, sb[0].a3);
            chk("mon_rf_wd", rf_wd, sb[0].wd);
         end
         mon_hit  = 1'b0;
         mon_data = '0;
         if (q_addr != '0) begin
            for (int i = 0; i < mon_n; i++) begin
               if (sb[i].a3 == q_addr) begin
                  mon_hit  = 1'b1;
                  mon_data = sb[i].wd;
               end
            end
         end
         chk("mon_q_hit", q_hit, mon_hit);
         chk("mon_q_data", q_data, mon_data);

         if (!reset || flush) begin
            sb.delete();
         end else begin
            if (rf_we && rf_grant) begin
               if (sb.size() == 0) begin
                  errors++;
                  checks++;
                  $display("FAIL mon_pop_empty: got rf_we=1 expected no entry");
               end else begin
                  void'(sb.pop_front());
               end
            end
            if (in_valid && in_ready && (in_a3 != '0))
               sb.push_back('{in_a3, exp_wd});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [AW-1:0] a3, input logic [1:0] sel,
                        input logic [31:0] alu, input logic [31:0] dm,
                        input logic [31:0] pc8, input logic [31:0] aux,
                        input logic [1:0] off, input logic [2:0] lw,
                        input logic [31:0] exp);
      in_valid  = 1'b1;
      in_a3     = a3;
      in_wd_sel = sel;
      in_alu    = alu;
      in_dm     = dm;
      in_pc8    = pc8;
      in_aux    = aux;
      in_off    = off;
      in_lw_sel = lw;
      exp_wd    = exp;
   endtask

   task automatic drain(input string name);
      rf_grant = 1'b1;
      in_valid = 1'b0;
      for (int i = 0; i < 20 && count != 0; i++) tick();
      chk(name, count, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{32'h80FF_0000, 2'd3, 3'b010, 32'hFFFF_FF80};
      vecs[1]  = '{32'h8001_1234, 2'd2, 3'b011, 32'h0000_8001};
      vecs[2]  = '{32'h8001_1234, 2'd0, 3'b100, 32'h0000_1234};
      vecs[3]  = '{32'h8001_1234, 2'd2, 3'b100, 32'hFFFF_8001};
      vecs[4]  = '{32'h8001_1234, 2'd3, 3'b100, 32'hFFFF_8001};
      vecs[5]  = '{32'h1234_5678, 2'd1, 3'b001, 32'h0000_0056};
      vecs[6]  = '{32'h1234_56F8, 2'd0, 3'b010, 32'hFFFF_FFF8};
      vecs[7]  = '{32'h1234_56F8, 2'd0, 3'b001, 32'h0000_00F8};
      vecs[8]  = '{32'hDEAD_BEEF, 2'd2, 3'b000, 32'hDEAD_BEEF};
      vecs[9]  = '{32'hDEAD_BEEF, 2'd1, 3'b101, 32'hDEAD_BEEF};
      vecs[10] = '{32'h00AB_0000, 2'd2, 3'b010, 32'hFFFF_FFAB};
      vecs[11] = '{32'h00AB_0000, 2'd1, 3'b011, 32'h0000_0000};

      reset    = 1'b0;
      flush    = 1'b0;
      rf_grant = 1'b0;
      q_addr   = 5'd3;
      // Reset wins over a concurrent push.
      drive(5'd3, 2'b00, 32'h33, 0, 0, 0, 2'd0, 3'b000, 32'h33);
      repeat (2) @(posedge clk);
      #1;
      reset    = 1'b1;
      in_valid = 1'b0;
      chk("rst_rf_we", rf_we, 0);
      chk("rst_rf_a3", rf_a3, 0);
      chk("rst_rf_wd", rf_wd, 0);
      chk("rst_count", count, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_q_hit", q_hit, 0);
      mon_en = 1'b1;

      // Load-extension table, each vector also retired through the queue.
      rf_grant = 1'b1;
      foreach (vecs[i]) begin
         drive(AW'(i + 1), 2'b01, 0, vecs[i].dm, 0, 0, vecs[i].off, vecs[i].lw, vecs[i].exp);
         #1;
         chk($sformatf("ext_%0d", i), dm_rd_ext, vecs[i].exp);
         tick();
      end
      drain("ext_drain");

      // lb and lhu single entries: 1-cycle latency, then immediate retire.
      drive(5'd8, 2'b01, 0, 32'h80FF_0000, 0, 0, 2'd3, 3'b010, 32'hFFFF_FF80);
      tick();
      in_valid = 1'b0;
      chk("lb_rf_we", rf_we, 1);
      chk("lb_rf_a3", rf_a3, 8);
      chk("lb_rf_wd", rf_wd, 32'hFFFF_FF80);
      tick();
      chk("lb_count", count, 0);
      chk("lb_hold_a3", rf_a3, 8);
      drive(5'd9, 2'b01, 0, 32'h8001_1234, 0, 0, 2'd2, 3'b011, 32'h0000_8001);
      tick();
      in_valid = 1'b0;
      chk("lhu_rf_wd", rf_wd, 32'h0000_8001);
      tick();
      // PC+8 and AUX sources.
      drive(5'd10, 2'b10, 1, 2, 32'h100, 4, 2'd0, 3'b000, 32'h100);
      tick();
      drive(5'd11, 2'b11, 1, 2, 3, 32'h5A5A, 2'd0, 3'b000, 32'h5A5A);
      tick();
      drain("src_drain");

      // Fill to DEPTH with grant low, hold a fifth push, then release.
      rf_grant = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive(AW'(k + 1), 2'b00, 32'(10 + k), 0, 0, 0, 2'd0, 3'b000, 32'(10 + k));
         tick();
      end
      chk("full_count", count, 4);
      chk("full_in_ready", in_ready, 0);
      drive(5'd6, 2'b00, 32'd14, 0, 0, 0, 2'd0, 3'b000, 32'd14);
      tick();
      tick();
      chk("full_hold_count", count, 4);
      rf_grant = 1'b1;
      tick();
      chk("full_first_pop_count", count, 3);
      chk("full_first_pop_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("full_push_pop_count", count, 3);
      drain("full_drain");

      // Forwarding: youngest match wins; a pushing entry does not hit.
      rf_grant = 1'b0;
      drive(5'd5, 2'b00, 32'hA, 0, 0, 0, 2'd0, 3'b000, 32'hA);
      tick();
      drive(5'd5, 2'b00, 32'hB, 0, 0, 0, 2'd0, 3'b000, 32'hB);
      tick();
      q_addr = 5'd7;
      drive(5'd7, 2'b00, 32'hC, 0, 0, 0, 2'd0, 3'b000, 32'hC);
      #1;
      chk("fwd_push_nohit", q_hit, 0);
      tick();
      in_valid = 1'b0;
      chk("fwd_hit7", q_hit, 1);
      chk("fwd_data7", q_data, 32'hC);
      q_addr = 5'd5;
      #1;
      chk("fwd_hit5", q_hit, 1);
      chk("fwd_data5", q_data, 32'hB);
      q_addr = 5'd0;
      #1;
      chk("fwd_zero_hit", q_hit, 0);
      chk("fwd_zero_data", q_data, 0);
      q_addr = 5'd9;
      #1;
      chk("fwd_miss", q_hit, 0);
      q_addr = 5'd5;
      drain("fwd_drain");

      // $0 write: handshake completes, nothing queued.
      drive(5'd0, 2'b00, 32'd99, 0, 0, 0, 2'd0, 3'b000, 32'd99);
      #1;
      chk("zero_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("zero_count", count, 0);
      chk("zero_rf_we", rf_we, 0);

`ifdef WB_FLUSH_EN
      rf_grant = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(AW'(k + 1), 2'b00, 32'(20 + k), 0, 0, 0, 2'd0, 3'b000, 32'(20 + k));
         tick();
      end
      q_addr = 5'd1;
      drive(5'd9, 2'b00, 32'd30, 0, 0, 0, 2'd0, 3'b000, 32'd30);
      rf_grant = 1'b1;
      flush    = 1'b1;
      #1;
      chk("flush_in_ready", in_ready, 0);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_count", count, 0);
      chk("flush_rf_we", rf_we, 0);
      chk("flush_q_hit", q_hit, 0);
`endif

      // Reset mid-operation with a concurrent push.
      rf_grant = 1'b0;
      for (int k = 0; k < 2; k++) begin
         drive(AW'(k + 1), 2'b00, 32'(40 + k), 0, 0, 0, 2'd0, 3'b000, 32'(40 + k));
         tick();
      end
      q_addr = 5'd1;
      drive(5'd3, 2'b00, 32'd42, 0, 0, 0, 2'd0, 3'b000, 32'd42);
      reset = 1'b0;
      tick();
      reset    = 1'b1;
      in_valid = 1'b0;
      chk("rst2_count", count, 0);
      chk("rst2_rf_we", rf_we, 0);
      chk("rst2_q_hit", q_hit, 0);
      chk("rst2_rf_a3", rf_a3, 0);
      chk("rst2_rf_wd", rf_wd, 0);

      rf_grant = 1'b1;
      drive(5'd4, 2'b00, 32'h77, 0, 0, 0, 2'd0, 3'b000, 32'h77);
      tick();
      in_valid = 1'b0;
      chk("post_rst_rf_wd", rf_wd, 32'h77);
      drain("final_drain");
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
